tdm_demux_1x8: RTL

Time-division 1-to-8 demultiplexer: the receive end of the 8-slot serial link whose transmit side is an 8:1 mux stepped through selects 000→111. Samples one serial bit per enabled cycle into slot `s2s1s0`, assembles a full frame in a shadow register, and presents all eight bits in parallel at once when the frame completes. A slot-0 marker aligns the slot counter, and misalignment is detected and flagged.

---
 rtl/tdm_demux_1x8.sv | 116 +++++++++++
 1 files changed

// File: rtl/tdm_demux_1x8.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_1x8
// Description : Receive end of an 8-slot serial TDM link. Assembles one bit per
//               enabled cycle into a shadow frame and publishes all 8 slots at
//               once; a slot-0 sync marker locks and realigns the slot counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_1x8 (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  input  logic sync,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3,
  output logic y4,
  output logic y5,
  output logic y6,
  output logic y7,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic frame_valid,
  output logic sync_err,
  output logic locked
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] SLOT_FIRST = 3'd0;
  localparam logic [2:0] SLOT_LAST  = 3'd7;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] sh;
  logic [7:0] sh_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic [7:0] frame;
  logic [7:0] frame_nxt;
  logic       fv_nxt;
  logic       serr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      sh          <= 8'h00;
      cnt         <= SLOT_FIRST;
      frame       <= 8'h00;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_nxt;
      sh          <= sh_nxt;
      cnt         <= cnt_nxt;
      frame       <= frame_nxt;
      frame_valid <= fv_nxt;
      sync_err    <= serr_nxt;
      locked      <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    frame_nxt = frame;
    fv_nxt    = 1'b0;
    serr_nxt  = 1'b0;

    case (state)
      HUNT: begin
        if (en && sync) begin
          sh_nxt[0] = din;
          cnt_nxt   = 3'd1;
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (en) begin
          if (sync && (cnt != SLOT_FIRST)) begin
            // Misaligned marker: drop the partial frame and restart at slot 1.
            serr_nxt  = 1'b1;
            sh_nxt[0] = din;
            cnt_nxt   = 3'd1;
          end else begin
            sh_nxt[cnt] = din;
            cnt_nxt     = cnt + 3'd1;
            if (cnt == SLOT_LAST) begin
              // Slot 7 bypasses the shadow so the frame publishes on this edge.
              frame_nxt = {din, sh[6:0]};
              fv_nxt    = 1'b1;
            end
          end
        end
      end

      default: begin
        state_nxt = HUNT;
      end
    endcase
  end

  assign {y7, y6, y5, y4, y3, y2, y1, y0} = frame;
  assign {s2, s1, s0}                     = cnt;

endmodule
`default_nettype wire
